// File: rtl/spi_acl2_pkg.sv
// Shared constants, register map and state encoding for the ACL2 SPI responder.
// Addresses are 6 bits wide, matching the 64-byte register file.
package spi_acl2_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h0A;
  localparam logic [7:0] CMD_READ    = 8'h0B;
  localparam logic [7:0] CMD_FIFO_RD = 8'h0D;

  localparam logic [5:0] ADDR_DEVID_AD   = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST  = 6'h01;
  localparam logic [5:0] ADDR_PARTID     = 6'h02;
  localparam logic [5:0] ADDR_XDATA      = 6'h08;
  localparam logic [5:0] ADDR_YDATA      = 6'h09;
  localparam logic [5:0] ADDR_ZDATA      = 6'h0A;
  localparam logic [5:0] ADDR_STATUS     = 6'h0B;
  localparam logic [5:0] ADDR_SOFT_RESET = 6'h1F;
  localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;

  localparam logic [5:0] WR_LO = 6'h20;
  localparam logic [5:0] WR_HI = 6'h2E;

  localparam logic [7:0] ID_AD          = 8'hAD;
  localparam logic [7:0] ID_MST         = 8'h1D;
  localparam logic [7:0] ID_PART        = 8'hF2;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_FIFO_RD,
    ST_IGNORE
  } state_t;

  function automatic logic is_writable(input logic [5:0] a);
    return (a >= WR_LO) && (a <= WR_HI);
  endfunction

endpackage

// File: rtl/spi_acl2_responder_fifo.sv
// Synchronous byte FIFO with registered full/empty flags; reading while empty
// returns zero and a pop on empty is ignored.
module spi_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spi_acl2_responder.sv
// SPI mode-0 device end of the ACL2 link: register read/write bursts, FIFO reads,
// 64-byte register file and 16-byte sample FIFO, all in the CLK domain.
module spi_acl2_responder
  import spi_acl2_pkg::*;
#(
  parameter int REG_DEPTH  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       SAMPLE_STROBE,
  input  logic [7:0] SAMPLE_X,
  input  logic [7:0] SAMPLE_Y,
  input  logic [7:0] SAMPLE_Z,
  input  logic       FIFO_WR_EN,
  input  logic [7:0] FIFO_WR_DATA,
  output logic       FIFO_FULL,
  output logic       FIFO_EMPTY,
  output logic [7:0] POWER_CTL,
  output logic       BUSY
);
  localparam int AW = $clog2(REG_DEPTH);

  logic          cs_p0, cs_p1;
  logic          sclk_p0, sclk_p1, sclk_p2;
  logic          mosi_p0, mosi_p1;
  logic          sclk_rise, sclk_fall, byte_done, wr_fire, armed;
  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sh;
  logic [7:0]    rx_byte, cmd_q, tx_sh, rd_mux;
  logic          miso_q;
  logic [AW-1:0] ptr, rd_addr;
  logic [7:0]    regs_q [REG_DEPTH];
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rd_data;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous SCLK for edge detect.
  always_ff @(posedge CLK) begin
    cs_p0   <= CS;
    sclk_p0 <= SCLK;
    mosi_p0 <= MOSI;
    mosi_p1 <= mosi_p0;
    if (RST) begin
      cs_p1   <= 1'b1;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
    end else begin
      cs_p1   <= cs_p0;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign rx_byte   = {rx_sh, mosi_p1};
  assign byte_done = sclk_rise & (bit_cnt == 3'd0) & ~cs_p1 & (state != ST_IDLE);
  assign wr_fire   = byte_done & (state == ST_WR_DATA);
  assign rd_addr   = (state == ST_ADDR) ? rx_byte[AW-1:0] : ptr + AW'(1);
  assign POWER_CTL = regs_q[ADDR_POWER_CTL];
  assign FIFO_FULL  = fifo_full;
  assign FIFO_EMPTY = fifo_empty;

  // armed stays low after RST until CS has really been seen high (cs_p0 is unreset).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cs_p1 && cs_p0) armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (cs_p1) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (armed) state_nxt = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) state_nxt = ST_ADDR;
            else if (rx_byte == CMD_FIFO_RD)                 state_nxt = ST_FIFO_RD;
            else                                             state_nxt = ST_IGNORE;
          end
        end
        ST_ADDR: if (byte_done) state_nxt = (cmd_q == CMD_READ) ? ST_RD_DATA : ST_WR_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    MISO     = 1'b0;
    BUSY     = ~cs_p1;
    fifo_pop = 1'b0;
    if (state == ST_RD_DATA || state == ST_FIFO_RD) MISO = miso_q;
    if (byte_done && ((state == ST_CMD && rx_byte == CMD_FIFO_RD) || state == ST_FIFO_RD))
      fifo_pop = 1'b1;
  end

  always_comb begin
    case (rd_addr)
      ADDR_DEVID_AD:  rd_mux = ID_AD;
      ADDR_DEVID_MST: rd_mux = ID_MST;
      ADDR_PARTID:    rd_mux = ID_PART;
      ADDR_STATUS:    rd_mux = {6'b0, fifo_full, ~fifo_empty};
      default:        rd_mux = regs_q[rd_addr];
    endcase
  end

  // Shift stage: MOSI captured on SCLK rise, MISO advanced on SCLK fall.
  always_ff @(posedge CLK) begin
    if (RST || state == ST_IDLE) bit_cnt <= 3'd7;
    else if (sclk_rise)          bit_cnt <= bit_cnt - 3'd1;

    if (sclk_rise) rx_sh <= rx_byte[6:0];

    if (state == ST_IDLE) begin
      tx_sh  <= 8'h00;
      miso_q <= 1'b0;
    end else if (sclk_fall) begin
      miso_q <= tx_sh[7];
      tx_sh  <= {tx_sh[6:0], 1'b0};
    end else if (fifo_pop) begin
      tx_sh <= fifo_rd_data;
    end else if (byte_done && ((state == ST_ADDR && cmd_q == CMD_READ) || state == ST_RD_DATA)) begin
      tx_sh <= rd_mux;
    end

    if (byte_done && state == ST_CMD) cmd_q <= rx_byte;

    if (byte_done) begin
      if (state == ST_ADDR)                               ptr <= rx_byte[AW-1:0];
      else if (state == ST_WR_DATA || state == ST_RD_DATA) ptr <= ptr + AW'(1);
    end
  end

  // Only writable addresses and the sample slots are ever loaded; the rest stay zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      if (wr_fire && ptr == ADDR_SOFT_RESET && rx_byte == SOFT_RESET_KEY) begin
        for (int i = 0; i < REG_DEPTH; i++)
          if (is_writable(AW'(i))) regs_q[i] <= 8'h00;
      end else if (wr_fire && is_writable(ptr)) begin
        regs_q[ptr] <= rx_byte;
      end
      if (SAMPLE_STROBE) begin
        regs_q[ADDR_XDATA] <= SAMPLE_X;
        regs_q[ADDR_YDATA] <= SAMPLE_Y;
        regs_q[ADDR_ZDATA] <= SAMPLE_Z;
      end
    end
  end

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (FIFO_WR_EN),
    .pop     (fifo_pop),
    .wr_data (FIFO_WR_DATA),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: doc/spi_acl2_responder.md
# spi_acl2_responder

Synthesizable SPI responder for the ACL2 accelerometer link: the device end of the three-wire-plus-CS bus that `spi_controller` drives. It decodes the instruction/address stream on MOSI, serves register reads, register writes and FIFO reads on MISO, and holds a 64-byte register file plus a 16-byte sample FIFO. It is used as an on-chip loopback target and as the bench slave for the SPI master.

## Interface
- `REG_DEPTH`, 64: register file bytes; address is 6 bits and wraps.
- `FIFO_DEPTH`, 16: sample FIFO depth in bytes.
- `CLK  in  1`: 125 MHz system clock; all logic on its rising edge.
- `RST  in  1`: reset; synchronous, active-high.
- `CS  in  1`: chip select, active low, asynchronous to CLK.
- `SCLK  in  1`: SPI clock, mode 0, asynchronous to CLK.
- `MOSI  in  1`: serial data from the master, MSB first.
- `MISO  out  1`: serial data to the master, MSB first.
- `SAMPLE_STROBE  in  1`: one-cycle pulse that loads `SAMPLE_X/Y/Z` into registers 0x08/0x09/0x0A.
- `SAMPLE_X`, `SAMPLE_Y`, `SAMPLE_Z`  `in  8`: axis sample bytes.
- `FIFO_WR_EN  in  1`, `FIFO_WR_DATA  in  8`: FIFO push port.
- `FIFO_FULL  out  1`, `FIFO_EMPTY  out  1`: FIFO status.
- `POWER_CTL  out  8`: live copy of register 0x2D.
- `BUSY  out  1`: high while `CS` is synchronized low.

## Operation
- `CS`, `SCLK` and `MOSI` each pass through a 2-FF synchronizer. Edge detect on the synchronized `SCLK`:
  - rise: sample MOSI.
  - fall: shift MISO.
- Instructions:
  - 0x0A: register write.
  - 0x0B: register read.
  - 0x0D: FIFO read.
- States:
  - IDLE: `CS` high. Bit counter = 7. MISO = 0.
  - CMD: 8 bits. 0x0A/0x0B go to ADDR. 0x0D goes to FIFO_RD. Any other code goes to IGNORE.
  - ADDR: 8 bits. Address pointer = `addr[5:0]`. 0x0B goes to RD_DATA and loads the shift register with `REG[ptr]`. 0x0A goes to WR_DATA.
  - WR_DATA: after 8 bits, write `REG[ptr]` if ptr is in the writable range 0x20–0x2E, else drop the byte. Then `ptr++`. Repeats per byte (burst).
  - RD_DATA: each time 8 bits have been shifted out, `ptr++` and load `REG[ptr]`. Repeats per byte (burst).
  - FIFO_RD: at state entry and after every 8 bits, pop one byte into the shift register. An empty FIFO yields 0x00 and does not pop.
  - IGNORE: MISO = 0 until `CS` rises.
- Read-only registers:
  - 0x00 = 0xAD, 0x01 = 0x1D, 0x02 = 0xF2.
  - 0x08–0x0A: axis samples.
  - 0x0B: status; bit0 = FIFO not empty, bit1 = FIFO full.
  - All other non-writable addresses read 0x00.
- Soft reset: writing 0x52 to 0x1F restores all writable registers to their reset value of 0x00. It does not clear the FIFO.
- Pointer wraps 0x3F -> 0x00 in both read and write bursts.

## Timing
- Reset values:
  - MISO = 0, `BUSY` = 0, `POWER_CTL` = 0x00.
  - `FIFO_EMPTY` = 1, `FIFO_FULL` = 0.
  - All registers at reset values; state IDLE.
- SCLK high and low phases are each ≥ 4 CLK. Synchronizer plus edge-detect latency is 3 CLK.
- The first read bit drives MISO within 3 CLK of the 16th `SCLK` fall (8th for FIFO_RD), i.e. before the next rise.
- Mid-transaction CS rise, detected within 3 CLK:
  - Abort to IDLE.
  - A partial write byte is discarded.
  - A byte already loaded or popped is consumed.
- `SAMPLE_STROBE` during a read: the shift register holds the byte loaded at byte start. The new sample shows on the next load.
- FIFO:
  - Push and pop in the same CLK: both happen and the count is unchanged.
  - Push when full: dropped, unless a pop occurs in the same cycle.
  - Status flags are registered and update the cycle after the event.
- `RST` mid-transaction: immediate return to IDLE. The next transaction starts only after `CS` has been seen high.

## Structure
- Package `spi_acl2_pkg`:
  - instruction codes 0x0A/0x0B/0x0D;
  - register addresses 0x00–0x02, 0x08–0x0B, 0x1F, 0x2D;
  - writable range bounds;
  - ID values; soft-reset key 0x52;
  - state encoding.
- Sub-module `spi_byte_fifo`: synchronous FIFO with push/pop, full/empty and an underflow-safe zero output.

## Test plan
- Read ID burst: CS low, send 0x0B 0x00, clock 3 bytes -> MISO returns 0xAD, 0x1D, 0xF2.
- Write then read: send 0x0A 0x2D 0x02, CS high, then 0x0B 0x2D -> reads 0x02 and `POWER_CTL` = 0x02. Writing 0x55 to 0x08 is ignored; 0x08 still holds its sample.
- Wrap: 0x0B 0x3F, 2 bytes -> `REG[0x3F]` then 0xAD.
- FIFO: push 0x11, 0x22; send 0x0D and clock 3 bytes -> 0x11, 0x22, 0x00, and `FIFO_EMPTY` = 1. Push 17 bytes -> `FIFO_FULL` = 1 and the 17th byte is dropped.
- Abort: raise CS after 4 bits of a 0x0A 0x20 data byte -> 0x20 unchanged and state IDLE. Soft reset 0x52 to 0x1F -> 0x2D reads 0x00.
- Sample race: `SAMPLE_STROBE` with X = 0x7F mid-read of 0x08 (old 0x10) -> current byte 0x10, next read 0x7F.
